// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the multiplexed 7-segment driver.
//   seg_t    : 8-bit active-low segment vector {p,g,f,e,d,c,b,a}
//   SEG_OFF  : all segments dark
//   SEG_FONT : 16-entry active-low {g,f,e,d,c,b,a} hex font
package seg7_pkg;

   typedef logic [7:0] seg_t;

   localparam seg_t SEG_OFF = 8'hFF;

   // Hex font, active-low, bit order {g,f,e,d,c,b,a}.
   // 6 and 9 carry tails; b and d are lowercase; A, C, E, F uppercase.
   localparam logic [6:0] SEG_FONT [16] = '{
      7'h40,  // 0
      7'h79,  // 1
      7'h24,  // 2
      7'h30,  // 3
      7'h19,  // 4
      7'h12,  // 5
      7'h02,  // 6
      7'h78,  // 7
      7'h00,  // 8
      7'h10,  // 9
      7'h08,  // A
      7'h03,  // b
      7'h46,  // C
      7'h21,  // d
      7'h06,  // E
      7'h0E   // F
   };

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble + decimal point to active-low segments.
//   nibble_i : hex digit to display
//   dp_i     : decimal point, active-high
//   seg_o    : {p,g,f,e,d,c,b,a}, active-low
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       dp_i,
   output seg_t       seg_o
);

   always_comb begin
      seg_o = {~dp_i, SEG_FONT[nibble_i]};
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex display driver for DIGITS common-anode digits.
// A prescaler divides the clock into SCAN_DIV-cycle slots; each slot shows one digit
// from a shadow register through a single shared decoder. an_o/seg_o are registered.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset
//   load_i  : capture data_i/dp_i into the shadow register
//   data_i  : packed hex nibbles, digit i = data_i[4i+3:4i], digit 0 rightmost
//   dp_i    : per-digit decimal point, active-high
//   blank_i : force display dark while the scan keeps running
//   an_o    : anode selects, active-low
//   seg_o   : {p,g,f,e,d,c,b,a}, active-low
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN enables leading-zero suppression.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned SCAN_DIV = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic [4*DIGITS-1:0]   data_i,
   input  logic [DIGITS-1:0]     dp_i,
   input  logic                  blank_i,
   output logic [DIGITS-1:0]     an_o,
   output seg_t                  seg_o
);

   localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned PreW = $clog2(SCAN_DIV);
   localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

   logic [PreW-1:0]     presc_q, presc_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [4*DIGITS-1:0] data_q, data_d;
   logic [DIGITS-1:0]   dp_q, dp_d;
   logic [DIGITS-1:0]   an_q, an_d;
   seg_t                seg_q, seg_d;

   logic                slot_end;
   logic [3:0]          nib_sel;
   logic                dp_sel;
   logic                lz_sel;
   logic [DIGITS-1:0]   lz_mask;
   seg_t                dec_seg;

   // Prescaler, digit index and shadow register next state
   always_comb begin
      slot_end = (presc_q == PreLast);
      presc_d  = slot_end ? '0 : presc_q + 1'b1;
      idx_d    = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end
      data_d = load_i ? data_i : data_q;
      dp_d   = load_i ? dp_i   : dp_q;
   end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic zero_run;

   // Walk down from the top digit; a digit is suppressed while it and everything
   // above it is a zero without a decimal point. Digit 0 always stays lit.
   always_comb begin
      zero_run = 1'b1;
      lz_mask  = '0;
      for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
         zero_run   = zero_run && (data_q[4*k +: 4] == 4'h0) && !dp_q[k];
         lz_mask[k] = (k != 0) && zero_run;
      end
   end
`else
   assign lz_mask = '0;
`endif

   // Select the scanned digit from the shadow register
   always_comb begin
      nib_sel = 4'h0;
      dp_sel  = 1'b0;
      lz_sel  = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx_q == IdxW'(i)) begin
            nib_sel = data_q[4*i +: 4];
            dp_sel  = dp_q[i];
            lz_sel  = lz_mask[i];
         end
      end
   end

   seg7_hex_decode u_dec (
      .nibble_i (nib_sel),
      .dp_i     (dp_sel),
      .seg_o    (dec_seg)
   );

   // Output next state; the last prescaler count is a dead slot with all anodes off
   always_comb begin
      for (int i = 0; i < int'(DIGITS); i++) begin
         an_d[i] = (idx_q != IdxW'(i));
      end
      seg_d = lz_sel ? SEG_OFF : dec_seg;
      if (blank_i || slot_end) begin
         an_d = '1;
      end
      if (blank_i) begin
         seg_d = SEG_OFF;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         presc_q <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         dp_q    <= '0;
         an_q    <= '1;
         seg_q   <= SEG_OFF;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         dp_q    <= dp_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign an_o  = an_q;
   assign seg_o = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench for seg7_scan_driver with DIGITS=4/SCAN_DIV=4
// and a second DIGITS=1 instance sharing clock, reset and load.
module tb_seg7_scan_driver;

   logic        clk;
   logic        rst;
   logic        load;
   logic [15:0] data;
   logic [3:0]  dp;
   logic        blank;
   logic [3:0]  an;
   logic [7:0]  seg;

   logic [3:0]  data1;
   logic        dp1;
   logic        blank1;
   logic        an1;
   logic [7:0]  seg1;

   int          n_checks;
   int          n_bad;
   int          cyc;
   logic [7:0]  seg_tab [4];
   logic [7:0]  lz_exp;

   seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4)) u_dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (load),
      .data_i  (data),
      .dp_i    (dp),
      .blank_i (blank),
      .an_o    (an),
      .seg_o   (seg)
   );

   seg7_scan_driver #(.DIGITS(1), .SCAN_DIV(4)) u_dut1 (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (load),
      .data_i  (data1),
      .dp_i    (dp1),
      .blank_i (blank1),
      .an_o    (an1),
      .seg_o   (seg1)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (cyc %0d)", tag, act, exp, cyc);
      end
   endtask

   // cyc counts edges since reset released; outputs after edge cyc reflect state cyc-1
   task automatic tick();
      @(posedge clk);
      #1;
      if (rst) cyc = 0;
      else     cyc++;
   endtask

   task automatic run_scan(input int n, input bit chk_seg);
      int s, p, i;
      logic [3:0] exp_an;
      for (int k = 0; k < n; k++) begin
         tick();
         s = cyc - 1;
         p = s % 4;
         i = (s / 4) % 4;
         exp_an = (p == 3) ? 4'hF : ~(4'b0001 << i);
         check_eq("an", {4'h0, an}, {4'h0, exp_an});
         check_eq("an1", {7'h0, an1}, {7'h0, (p == 3)});
         if (p != 3) begin
            check_eq("seg1", seg1, 8'hC0);
            if (chk_seg) check_eq("seg", seg, seg_tab[i]);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_bad    = 0;
      cyc      = 0;
      clk      = 1'b0;
      rst      = 1'b1;
      load     = 1'b0;
      data     = 16'h0000;
      dp       = 4'b0000;
      blank    = 1'b0;
      data1    = 4'h0;
      dp1      = 1'b0;
      blank1   = 1'b0;

      // Reset state
      tick();
      check_eq("rst_an", {4'h0, an}, 8'h0F);
      check_eq("rst_seg", seg, 8'hFF);
      check_eq("rst_an1", {7'h0, an1}, 8'h01);
      check_eq("rst_seg1", seg1, 8'hFF);

      // First cycle out of reset shows digit 0 = 0, then a full scan of zeros
      rst  = 1'b0;
      load = 1'b1;
      tick();
      check_eq("first_an", {4'h0, an}, 8'h0E);
      check_eq("first_seg", seg, 8'hC0);
      load = 1'b0;
      for (int i = 0; i < 4; i++) seg_tab[i] = 8'hC0;
      run_scan(15, 1'b1);

      // 1A8F with dp on digit 1
      data = 16'h1A8F;
      dp   = 4'b0010;
      load = 1'b1;
      run_scan(1, 1'b0);
      load = 1'b0;
      seg_tab[0] = 8'h8E;
      seg_tab[1] = 8'h00;
      seg_tab[2] = 8'h88;
      seg_tab[3] = 8'hF9;
      run_scan(18, 1'b1);

      // Blank for 10 cycles mid-scan; scan position keeps advancing underneath
      blank = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         check_eq("blank_an", {4'h0, an}, 8'h0F);
         check_eq("blank_seg", seg, 8'hFF);
      end
      blank = 1'b0;
      run_scan(8, 1'b1);

      // Mid-slot reset after loading FFFF clears the shadow register
      data = 16'hFFFF;
      dp   = 4'b0000;
      load = 1'b1;
      run_scan(1, 1'b0);
      load = 1'b0;
      for (int i = 0; i < 4; i++) seg_tab[i] = 8'h8E;
      run_scan(2, 1'b1);
      rst = 1'b1;
      tick();
      check_eq("mrst_an", {4'h0, an}, 8'h0F);
      check_eq("mrst_seg", seg, 8'hFF);
      check_eq("mrst_an1", {7'h0, an1}, 8'h01);
      rst = 1'b0;
      tick();
      check_eq("post_an", {4'h0, an}, 8'h0E);
      check_eq("post_seg", seg, 8'hC0);
      for (int i = 0; i < 4; i++) seg_tab[i] = 8'hC0;
      run_scan(3, 1'b1);

      // Leading zeros: 0050
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      lz_exp = 8'hFF;
`else
      lz_exp = 8'hC0;
`endif
      data = 16'h0050;
      load = 1'b1;
      run_scan(1, 1'b0);
      load = 1'b0;
      seg_tab[0] = 8'hC0;
      seg_tab[1] = 8'h92;
      seg_tab[2] = lz_exp;
      seg_tab[3] = lz_exp;
      run_scan(16, 1'b1);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, multiplexed hex 7-segment display driver for DIGITS common-anode digits.
- Latches a packed hex word and per-digit decimal points into a shadow register.
- Scans one digit at a time at a programmable rate and decodes each nibble to active-low segments.
- Sits between the datapath and board display pins, replacing per-digit combinational decoders with one time-shared decoder.

## Interface
- DIGITS, 4: number of digits scanned; legal 1..8.
- SCAN_DIV, 16: clock cycles per digit slot; legal ≥ 2.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  capture data/dp into the shadow register on this edge.
- data  in  4*DIGITS  hex nibbles; digit i = data[4i+3:4i]; digit 0 is rightmost.
- dp  in  DIGITS  decimal point per digit, active-high.
- blank  in  1  force display dark; scan continues.
- an  out  DIGITS  anode select, active-low, one-hot-low when lit.
- seg  out  8  {p,g,f,e,d,c,b,a}, active-low.

## Operation
- Reset: prescaler=0, index=0, shadow data=0, shadow dp=0, an=all ones, seg=8'hFF.
- Prescaler counts 0..SCAN_DIV-1 and wraps. On the wrap cycle, index advances; DIGITS-1 wraps to 0.
- Index width is max(1, $clog2(DIGITS)).
- load=1 writes data/dp into the shadow register. The scan always reads the shadow register, never the live inputs.
- Decode font:
  - 0-9 standard; 6 and 9 with tails.
  - A uppercase; b lowercase; C uppercase; d lowercase; E, F uppercase.
  - Segments off per digit: 1 → a,d,e,f,g; 4 → a,d,e; 7 → d,e,f,g; A → d; F → b,c,d.
- p = ~dp[index].
- Dead time: while prescaler == SCAN_DIV-1, an=all ones, which suppresses ghosting on the digit change.
- blank=1: an=all ones and seg=8'hFF. The prescaler and index keep running.
- Simultaneous load and blank: both take effect; the new data shows once blank drops.
- Mid-operation reset: everything returns to reset values on that edge, including the shadow register.

## Timing
- an and seg are registered, with one cycle of latency from the prescaler/index state.
  - Digit i is driven on cycles where the previous-cycle state was index=i and prescaler < SCAN_DIV-1.
- First cycle after rst falls: outputs show digit 0 using shadow value 0 (seg=8'hC0, an[0]=0).
- load → new value visible on seg at the second edge after the load edge, if that digit is currently scanned.
- blank → dark at the first edge after blank is sampled high; relit at the first edge after blank is sampled low.
- Full refresh period = DIGITS*SCAN_DIV cycles.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN defined: leading-zero suppression is enabled.
  - Digit k is blanked (seg=8'hFF, an still asserted) when nibble k and every higher nibble are 0 and dp of all of those digits is 0.
  - Digit 0 is never blanked.
  - Computed from the shadow register.
- SEG7_LEADING_ZERO_BLANK_EN undefined: all digits are always displayed and the suppression logic is absent.

## Structure
- Package seg7_pkg:
  - SEG_OFF = 8'hFF.
  - 16-entry active-low 7-bit font constant array.
  - seg_t typedef.
- Sub-module seg7_hex_decode: combinational nibble+dp → 8-bit seg using seg7_pkg, instantiated once.
- Top holds the prescaler, index counter, shadow register, leading-zero logic and output registers.

## Test plan
- Reset then load data=16'h0000, DIGITS=4, SCAN_DIV=4 → an cycles 1110,1101,1011,0111, each low for 3 of 4 cycles. Dead cycle has an=1111.
- load data=16'h1A8F, dp=4'b0010 → digit0 seg=8'h8E, digit1 seg=8'h00, digit2 seg=8'h88, digit3 seg=8'hF9.
- blank high for 10 cycles mid-scan → an=1111, seg=8'hFF for those cycles. On release, the scan resumes at the index implied by the uninterrupted count.
- rst asserted mid-slot after load 16'hFFFF → next cycle an=1111, seg=8'hFF; then digit 0 shows seg=8'hC0.
- With SEG7_LEADING_ZERO_BLANK_EN, load 16'h0050 → digits 3 and 2 seg=8'hFF, digit1 seg=8'h92, digit0 seg=8'hC0. Without the macro, digits 3 and 2 show 8'hC0.
- DIGITS=1: an[0] low except on the dead cycle. Index stays 0 across wraps.
